// File: rtl/sound_pkg.sv
// Shared types and default sizing for the sound blocks (crash writer, bang generator).
package sound_pkg;

  localparam int CRSH_W = 4;
  typedef logic [CRSH_W-1:0] crsh_t;

  localparam int CRSH_FIFO_DEPTH = 4;
  localparam int CRSH_HOLD_TICKS = 1;

endpackage

// File: rtl/crsh_writer_if.sv
// CPU-side write port and status of the crash writer; master is the CPU/decoder side.
interface crsh_writer_if
  import sound_pkg::*;
#(
  parameter int DEPTH = CRSH_FIFO_DEPTH
);

  logic                     wr_en;
  crsh_t                    wr_data;
  logic                     ovf_clr;
  crsh_t                    crsh;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  crsh, fifo_empty, fifo_full, overflow, level
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output crsh, fifo_empty, fifo_full, overflow, level
  );

endinterface

// File: rtl/crsh_fifo.sv
// Circular queue of crash values; a write while full with no pop replaces the newest entry.
module crsh_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH = CRSH_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  crsh_t                  wr_data,
  output crsh_t                  rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_event
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  crsh_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // A pop on the same edge frees a slot, so a write to a full queue is then a normal push.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign ovf_event = push && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (ovf_event) begin
        mem[wr_ptr - 1'b1] <= wr_data;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/crsh_writer.sv
// Queues CPU crash writes and presents one per eligible 48 kHz tick, each held HOLD_TICKS ticks.
module crsh_writer
  import sound_pkg::*;
#(
  parameter int DEPTH      = CRSH_FIFO_DEPTH,
  parameter int HOLD_TICKS = CRSH_HOLD_TICKS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en_48KHz,
  crsh_writer_if.slave bus
);

  crsh_t                   rd_data;
  crsh_t                   crsh_q;
  logic [7:0]              hold_cnt;
  logic                    overflow_q;
  logic                    ovf_event;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    pop;

  // Only registered fifo state is used here, so a write can never reach crsh on its own edge.
  assign pop = clk_en_48KHz && (hold_cnt == 8'd0) && !fifo_empty;

  crsh_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_en),
    .pop       (pop),
    .wr_data   (bus.wr_data),
    .rd_data   (rd_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf_event (ovf_event)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crsh_q   <= '0;
      hold_cnt <= 8'd0;
    end else if (pop) begin
      crsh_q   <= rd_data;
      hold_cnt <= 8'(HOLD_TICKS - 1);
    end else if (clk_en_48KHz && hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow_q <= 1'b0;
    else if (ovf_event)    overflow_q <= 1'b1;
    else if (bus.ovf_clr)  overflow_q <= 1'b0;
  end

  assign bus.crsh       = crsh_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_full  = fifo_full;
  assign bus.level      = fifo_level;

endmodule

// File: tb/tb_crsh_writer.sv
// Scoreboard bench for crsh_writer: one instance with HOLD_TICKS=1 (a) and one with HOLD_TICKS=3 (b).
module tb_crsh_writer;
  import sound_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic tick;

  int total = 0;
  int bad   = 0;

  crsh_t exp_a[$];
  crsh_t exp_b[$];
  crsh_t prev_a;
  crsh_t prev_b;

  crsh_writer_if #(.DEPTH(4)) ia ();
  crsh_writer_if #(.DEPTH(4)) ib ();

  crsh_writer #(.DEPTH(4), .HOLD_TICKS(1)) dut_a (
    .clk(clk), .reset(reset), .clk_en_48KHz(tick), .bus(ia)
  );

  crsh_writer #(.DEPTH(4), .HOLD_TICKS(3)) dut_b (
    .clk(clk), .reset(reset), .clk_en_48KHz(tick), .bus(ib)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns #1 after the edge that consumed it.
  task automatic applyStimulus(input logic t, input logic wa, input crsh_t da,
                               input logic wb, input crsh_t db, input logic clr);
    tick        = t;
    ia.wr_en    = wa;
    ia.wr_data  = da;
    ib.wr_en    = wb;
    ib.wr_data  = db;
    ia.ovf_clr  = clr;
    ib.ovf_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_a = ia.crsh;
      prev_b = ib.crsh;
    end else begin
      if (ia.crsh !== prev_a) begin
        if (exp_a.size() == 0) checkOutput("a_unexpected_crsh", int'(ia.crsh), -1);
        else checkOutput("a_pop", int'(ia.crsh), int'(exp_a.pop_front()));
        prev_a = ia.crsh;
      end
      if (ib.crsh !== prev_b) begin
        if (exp_b.size() == 0) checkOutput("b_unexpected_crsh", int'(ib.crsh), -1);
        else checkOutput("b_pop", int'(ib.crsh), int'(exp_b.pop_front()));
        prev_b = ib.crsh;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    tick = 1'b0;
    ia.wr_en = 1'b0; ia.wr_data = '0; ia.ovf_clr = 1'b0;
    ib.wr_en = 1'b0; ib.wr_data = '0; ib.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_crsh", int'(ia.crsh), 0);
    checkOutput("rst_empty", int'(ia.fifo_empty), 1);
    checkOutput("rst_full", int'(ia.fifo_full), 0);
    checkOutput("rst_level", int'(ia.level), 0);
    doTicks(10);
    checkOutput("idle_crsh", int'(ia.crsh), 0);
    checkOutput("idle_empty", int'(ia.fifo_empty), 1);
    checkOutput("idle_level", int'(ia.level), 0);
    checkOutput("idle_ovf", int'(ia.overflow), 0);

    // HOLD_TICKS=1: three writes step out on three successive ticks
    exp_a.push_back(4'd5); applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
    exp_a.push_back(4'd9); applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
    exp_a.push_back(4'd3); applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("a_level3", int'(ia.level), 3);
    doTicks(1); checkOutput("a_tick1", int'(ia.crsh), 5);
    doTicks(1); checkOutput("a_tick2", int'(ia.crsh), 9);
    doTicks(1); checkOutput("a_tick3", int'(ia.crsh), 3);
    checkOutput("a_empty_after", int'(ia.fifo_empty), 1);

    // HOLD_TICKS=3: second value waits out the hold
    exp_b.push_back(4'd7); applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
    exp_b.push_back(4'd2); applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    doTicks(1); checkOutput("b_hold_t1", int'(ib.crsh), 7);
    doTicks(1); checkOutput("b_hold_t2", int'(ib.crsh), 7);
    doTicks(1); checkOutput("b_hold_t3", int'(ib.crsh), 7);
    doTicks(1); checkOutput("b_hold_t4", int'(ib.crsh), 2);

    // Fill, then overwrite the newest entry
    for (int v = 1; v <= 4; v++) begin
      exp_b.push_back(crsh_t'(v));
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, crsh_t'(v), 1'b0);
    end
    checkOutput("b_full", int'(ib.fifo_full), 1);
    checkOutput("b_ovf_before", int'(ib.overflow), 0);
    exp_b[exp_b.size()-1] = 4'd6;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("b_ovf_set", int'(ib.overflow), 1);
    checkOutput("b_ovf_level", int'(ib.level), 4);
    checkOutput("b_ovf_full", int'(ib.fifo_full), 1);
    doTicks(12);
    checkOutput("b_drain_crsh", int'(ib.crsh), 6);
    checkOutput("b_drain_empty", int'(ib.fifo_empty), 1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("b_ovf_clr", int'(ib.overflow), 0);

    // Full queue, write on the same edge as a pop tick
    doTicks(2);
    for (int v = 10; v <= 13; v++) begin
      exp_b.push_back(crsh_t'(v));
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, crsh_t'(v), 1'b0);
    end
    checkOutput("b_full2", int'(ib.fifo_full), 1);
    exp_b.push_back(4'd8);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("b_pp_crsh", int'(ib.crsh), 10);
    checkOutput("b_pp_level", int'(ib.level), 4);
    checkOutput("b_pp_ovf", int'(ib.overflow), 0);
    doTicks(12);
    checkOutput("b_pp_last", int'(ib.crsh), 8);
    checkOutput("b_pp_empty", int'(ib.fifo_empty), 1);

    // Asynchronous reset with three entries queued
    for (int v = 1; v <= 3; v++) begin
      exp_a.push_back(crsh_t'(v * 4));
      applyStimulus(1'b0, 1'b1, crsh_t'(v * 4), 1'b0, 4'd0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("a_pre_rst_level", int'(ia.level), 3);
    #1 reset = 1'b1;
    #1;
    checkOutput("arst_crsh", int'(ia.crsh), 0);
    checkOutput("arst_level", int'(ia.level), 0);
    checkOutput("arst_empty", int'(ia.fifo_empty), 1);
    checkOutput("arst_full", int'(ia.fifo_full), 0);
    checkOutput("arst_b_crsh", int'(ib.crsh), 0);
    exp_a.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    doTicks(1);
    checkOutput("post_rst_crsh", int'(ia.crsh), 0);
    checkOutput("post_rst_empty", int'(ia.fifo_empty), 1);

    checkOutput("a_sb_left", exp_a.size(), 0);
    checkOutput("b_sb_left", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crsh_writer.md
Name: crsh_writer

Overview:
- CPU-facing writer end of the 4-bit crash (crsh) control that feeds the bang generator.
- The bang generator samples crsh only on clk_en_48KHz and is excited by each change, so CPU writes arriving faster than 48 kHz would be lost.
- This block queues CPU writes and presents them on crsh one per eligible 48 kHz tick, holding each value for a programmable minimum number of ticks.
- Sits between the sound-latch address decode and the bang instance.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- HOLD_TICKS, 1, minimum number of 48 kHz ticks each presented value is held; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en_48KHz  in  1  one-clk-wide sample tick, shared with bang.
- wr_en  in  1  CPU write strobe, one clk per write.
- wr_data  in  4  crash value written by CPU.
- ovf_clr  in  1  clears overflow flag.
- crsh  out  4  registered value presented to bang.
- fifo_empty  out  1  queue holds no entries.
- fifo_full  out  1  queue holds DEPTH entries.
- overflow  out  1  sticky: a write arrived while full.
- level  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - crsh=0, level=0, fifo_empty=1, fifo_full=0, overflow=0, hold_cnt=0.
  - Queue contents are discarded; pointers=0.
- Internal state:
  - Circular queue with wr_ptr/rd_ptr, wrap at DEPTH.
  - hold_cnt: 8 bits, ticks remaining before the next pop is allowed.
- Pop condition: clk_en_48KHz=1 and hold_cnt==0 and level>0. On pop:
  - crsh <= entry[rd_ptr]; rd_ptr increments; level decrements.
  - hold_cnt <= HOLD_TICKS-1.
- Tick with hold_cnt>0: hold_cnt decrements and crsh is unchanged.
- Tick with hold_cnt==0 and the queue empty: crsh holds its last value, with no change toward zero.
- Push: wr_en=1 and level<DEPTH stores wr_data at wr_ptr; wr_ptr increments; level increments.
- No bypass: a write on cycle N is never presented before the first pop-eligible tick strictly after N.
  - Minimum latency is 1 tick edge.
  - With an empty queue and hold expired, crsh updates on the first tick at cycle >N.
- Simultaneous push and pop on the same edge:
  - Both happen; level is unchanged.
  - When full, the pop frees the slot: the write is accepted and overflow is not set.
- Write while full with no pop that edge:
  - Newest entry (wr_ptr-1) is overwritten with wr_data; last write wins.
  - overflow <= 1; pointers and level are unchanged.
- overflow is cleared by ovf_clr. If ovf_clr and a new overflow occur on the same edge, set wins.
- Equal consecutive values are queued normally; no coalescing of duplicates.
- Flags are derived from registered level and update the edge after push/pop. fifo_full = (level==DEPTH); fifo_empty = (level==0).
- Ticks are assumed at least 2 clk apart; back-to-back ticks are still handled correctly by the rules above.

Decomposition:
- Package sound_pkg:
  - typedef crsh_t = logic[3:0].
  - Localparam CRSH_W=4.
  - Default DEPTH and HOLD_TICKS constants, shared with bang and other sound blocks.
- Sub-module crsh_fifo (parameter DEPTH):
  - Storage, pointers, level, full/empty.
  - Overwrite-newest-on-full behaviour and overflow detect output.
- crsh_writer owns hold_cnt, pop scheduling, the crsh register and the sticky overflow.

Test Plan:
- Reset then idle 10 ticks -> crsh=0, fifo_empty=1, level=0, overflow=0.
- HOLD_TICKS=1; write 5,9,3 on consecutive clks between ticks -> crsh steps 5, 9, 3 on the next three ticks; fifo_empty=1 after the third.
- HOLD_TICKS=3; write 7 then 2 -> crsh=7 on tick 1, unchanged on ticks 2–3, crsh=2 on tick 4.
- DEPTH=4, hold large; write 1,2,3,4 (full) then 6 -> fifo_full=1, overflow=1, level=4; pops yield 1,2,3,6; ovf_clr -> overflow=0.
- Full queue; wr_en=8 on the same clk as a pop tick -> pop presents head, 8 is accepted, overflow stays 0, level stays 4.
- Queue holding 3 entries; assert reset asynchronously between clk edges -> outputs go to reset values immediately; next tick leaves crsh=0.
